// File: rtl/phase_controller.sv
// rtl/phase_controller.sv - eight-phase instruction sequencer with control decode; CTRL_INSTR_COUNT_EN adds a retired-instruction counter
package opcodes;
   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;
endpackage

module phase_controller
   import opcodes::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  opcode_t          opcode,
   input  logic             zero,
   output logic             sel,
   output logic             rd,
   output logic             ld_ir,
   output logic             inc_pc,
   output logic             halt,
   output logic             ld_pc,
   output logic             data_e,
   output logic             ld_ac,
   output logic             wr,
   output logic [2:0]       phase
`ifdef CTRL_INSTR_COUNT_EN
   ,
   output logic [COUNT_W-1:0] instr_count
`endif
);

   typedef enum logic [2:0] {
      PH_INST_ADDR  = 3'd0,
      PH_INST_FETCH = 3'd1,
      PH_INST_LOAD  = 3'd2,
      PH_IDLE       = 3'd3,
      PH_OP_ADDR    = 3'd4,
      PH_OP_FETCH   = 3'd5,
      PH_ALU_OP     = 3'd6,
      PH_STORE      = 3'd7
   } phase_t;

   if (COUNT_W < 1) begin : g_count_w_check
      $error("COUNT_W must be at least 1");
   end

   phase_t phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   hlt_decode;
   logic   aluop;
   logic   step_en;

   assign hlt_decode = (phase_q == PH_OP_ADDR) && (opcode == HLT);
   assign aluop      = (opcode == ADD) || (opcode == AND) ||
                       (opcode == XOR) || (opcode == LDA);
   // A step is any edge that may change state; a HLT step latches halt instead of advancing.
   assign step_en    = run && !halted_q;

   // Next phase and halted flag: HLT in OP_ADDR freezes the sequencer at phase 4.
   always_comb begin
      phase_d  = phase_q;
      halted_d = halted_q;
      if (step_en) begin
         if (hlt_decode) begin
            halted_d = 1'b1;
         end else begin
            phase_d = phase_t'(3'(phase_q + 3'd1));
         end
      end
   end

   // Phase and halted state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q  <= PH_INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   // Control decode: purely combinational from phase, opcode and zero; halted masks side effects.
   always_comb begin
      sel    = 1'b0;
      rd     = 1'b0;
      ld_ir  = 1'b0;
      inc_pc = 1'b0;
      ld_pc  = 1'b0;
      data_e = 1'b0;
      ld_ac  = 1'b0;
      wr     = 1'b0;
      halt   = halted_q || hlt_decode;
      case (phase_q)
         PH_INST_ADDR: begin
            sel = 1'b1;
         end
         PH_INST_FETCH: begin
            sel = 1'b1;
            rd  = 1'b1;
         end
         PH_INST_LOAD, PH_IDLE: begin
            sel   = 1'b1;
            rd    = 1'b1;
            ld_ir = 1'b1;
         end
         PH_OP_ADDR: begin
            inc_pc = 1'b1;
         end
         PH_OP_FETCH: begin
            rd = aluop;
         end
         PH_ALU_OP: begin
            rd     = aluop;
            inc_pc = (opcode == SKZ) && zero;
            ld_pc  = (opcode == JMP);
            data_e = (opcode == STO);
         end
         PH_STORE: begin
            rd     = aluop;
            ld_pc  = (opcode == JMP);
            data_e = (opcode == STO);
            ld_ac  = aluop;
            wr     = (opcode == STO);
         end
         default: begin
            sel = 1'b0;
         end
      endcase
      if (halted_q) begin
         rd     = 1'b0;
         ld_ir  = 1'b0;
         inc_pc = 1'b0;
         ld_pc  = 1'b0;
         data_e = 1'b0;
         ld_ac  = 1'b0;
         wr     = 1'b0;
      end
   end

   assign phase = phase_q;

`ifdef CTRL_INSTR_COUNT_EN
   logic [COUNT_W-1:0] count_q, count_d;

   // An instruction retires on the edge that wraps STORE back to INST_ADDR.
   always_comb begin
      count_d = count_q;
      if (step_en && (phase_q == PH_STORE)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Retired-instruction counter register; wraps naturally at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_phase_controller.sv
// tb/tb_phase_controller.sv - self-checking bench for phase_controller
module tb_phase_controller;
   import opcodes::*;

`ifdef CTRL_INSTR_COUNT_EN
   localparam int CW = 4;
`else
   localparam int CW = 16;
`endif

   logic    clk = 1'b0;
   logic    rst = 1'b1;
   logic    run = 1'b0;
   opcode_t opcode = ADD;
   logic    zero = 1'b0;
   logic    sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;
   logic [2:0] phase;
`ifdef CTRL_INSTR_COUNT_EN
   logic [CW-1:0] instr_count;
`endif

   phase_controller #(.COUNT_W(CW)) dut (
      .clk    (clk),
      .rst    (rst),
      .run    (run),
      .opcode (opcode),
      .zero   (zero),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .inc_pc (inc_pc),
      .halt   (halt),
      .ld_pc  (ld_pc),
      .data_e (data_e),
      .ld_ac  (ld_ac),
      .wr     (wr),
      .phase  (phase)
`ifdef CTRL_INSTR_COUNT_EN
      ,
      .instr_count (instr_count)
`endif
   );

   always #5 clk = ~clk;

   logic [8:0] dut_vec;
   assign dut_vec = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

   int checks = 0;
   int errors = 0;

   // Reference model state: phase number, halted flag, retired count.
   int m_phase  = 0;
   bit m_halted = 0;
   int m_count  = 0;

   typedef struct {
      opcode_t    op;
      logic       z;
      logic [7:0] rd_m;
      logic [7:0] inc_m;
      logic [7:0] ldpc_m;
      logic [7:0] de_m;
      logic [7:0] ldac_m;
      logic [7:0] wr_m;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [8:0] exp_out(int ph, opcode_t op, logic z, bit hq);
      bit aluop, s, r, li, ip, h, lp, de, la, w;
      aluop = (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
      s  = (ph <= 3);
      r  = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
      li = (ph == 2 || ph == 3);
      ip = (ph == 4) || (ph == 6 && op == SKZ && z);
      h  = hq || (ph == 4 && op == HLT);
      lp = (ph >= 6) && (op == JMP);
      de = (ph >= 6) && (op == STO);
      la = (ph == 7) && aluop;
      w  = (ph == 7) && (op == STO);
      if (hq) begin
         r = 0; li = 0; ip = 0; lp = 0; de = 0; la = 0; w = 0;
      end
      return {s, r, li, ip, h, lp, de, la, w};
   endfunction

   task automatic model_reset();
      m_phase  = 0;
      m_halted = 0;
      m_count  = 0;
   endtask

   task automatic apply(input logic r, input opcode_t op, input logic z);
      run = r; opcode = op; zero = z;
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, " phase"}, 32'(phase), 32'(m_phase));
      chk({tag, " outputs"}, 32'(dut_vec), 32'(exp_out(m_phase, opcode, zero, m_halted)));
`ifdef CTRL_INSTR_COUNT_EN
      chk({tag, " instr_count"}, 32'(instr_count), 32'(m_count % (1 << CW)));
`endif
   endtask

   task automatic clk_edge();
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else if (run && !m_halted) begin
         if (m_phase == 4 && opcode == HLT) begin
            m_halted = 1;
         end else begin
            if (m_phase == 7) m_count++;
            m_phase = (m_phase + 1) % 8;
         end
      end
      @(negedge clk);
   endtask

   task automatic async_reset(input string tag);
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      chk({tag, " async phase"}, 32'(phase), 32'd0);
      chk({tag, " async halt"}, 32'(halt), 32'd0);
      chk({tag, " async outputs"}, 32'(dut_vec), 32'h100);
      clk_edge();
      rst = 1'b0;
   endtask

   initial begin
      tbl[0] = '{ADD, 1'b0, 8'b1110_1110, 8'b0001_0000, 8'h00,        8'h00,        8'b1000_0000, 8'h00};
      tbl[1] = '{SKZ, 1'b1, 8'b0000_1110, 8'b0101_0000, 8'h00,        8'h00,        8'h00,        8'h00};
      tbl[2] = '{SKZ, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'h00,        8'h00,        8'h00,        8'h00};
      tbl[3] = '{STO, 1'b0, 8'b0000_1110, 8'b0001_0000, 8'h00,        8'b1100_0000, 8'h00,        8'b1000_0000};
      tbl[4] = '{JMP, 1'b1, 8'b0000_1110, 8'b0001_0000, 8'b1100_0000, 8'h00,        8'h00,        8'h00};
      tbl[5] = '{LDA, 1'b1, 8'b1110_1110, 8'b0001_0000, 8'h00,        8'h00,        8'b1000_0000, 8'h00};

      // Reset state.
      rst = 1'b1;
      @(negedge clk);
      apply(1'b1, ADD, 1'b0);
      chk("reset phase", 32'(phase), 32'd0);
      chk("reset outputs", 32'(dut_vec), 32'h100);
      clk_edge();
      chk("reset holds phase", 32'(phase), 32'd0);
      rst = 1'b0;
      model_reset();

      // Table-driven: one full instruction per record, checked phase by phase.
      for (int i = 0; i < 6; i++) begin
         for (int p = 0; p < 8; p++) begin
            apply(1'b1, tbl[i].op, tbl[i].z);
            chk($sformatf("tbl%0d ph%0d phase", i, p), 32'(phase), 32'(p));
            chk($sformatf("tbl%0d ph%0d sel", i, p), 32'(sel), 32'(p <= 3));
            chk($sformatf("tbl%0d ph%0d ld_ir", i, p), 32'(ld_ir), 32'(p == 2 || p == 3));
            chk($sformatf("tbl%0d ph%0d rd", i, p), 32'(rd), 32'(tbl[i].rd_m[p]));
            chk($sformatf("tbl%0d ph%0d inc_pc", i, p), 32'(inc_pc), 32'(tbl[i].inc_m[p]));
            chk($sformatf("tbl%0d ph%0d ld_pc", i, p), 32'(ld_pc), 32'(tbl[i].ldpc_m[p]));
            chk($sformatf("tbl%0d ph%0d data_e", i, p), 32'(data_e), 32'(tbl[i].de_m[p]));
            chk($sformatf("tbl%0d ph%0d ld_ac", i, p), 32'(ld_ac), 32'(tbl[i].ldac_m[p]));
            chk($sformatf("tbl%0d ph%0d wr", i, p), 32'(wr), 32'(tbl[i].wr_m[p]));
            chk($sformatf("tbl%0d ph%0d halt", i, p), 32'(halt), 32'd0);
            clk_edge();
         end
         chk($sformatf("tbl%0d wrapped", i), 32'(phase), 32'd0);
`ifdef CTRL_INSTR_COUNT_EN
         chk($sformatf("tbl%0d instr_count", i), 32'(instr_count), 32'(i + 1));
`endif
      end

`ifdef CTRL_INSTR_COUNT_EN
      // Ten more instructions: count goes 6 -> 15 -> wraps to 0.
      for (int n = 0; n < 80; n++) begin
         apply(1'b1, ADD, 1'b0);
         clk_edge();
         if (n == 71) chk("count at 15", 32'(instr_count), 32'd15);
      end
      chk("count wrap to 0", 32'(instr_count), 32'd0);
`endif

      // Hold with run=0 at phase 2, then resume; async reset at phase 5.
      async_reset("pre-hold");
      for (int n = 0; n < 2; n++) begin apply(1'b1, ADD, 1'b0); clk_edge(); end
      for (int n = 0; n < 5; n++) begin
         apply(1'b0, ADD, 1'b0);
         chk_model($sformatf("hold%0d", n));
         chk($sformatf("hold%0d phase", n), 32'(phase), 32'd2);
         clk_edge();
      end
      apply(1'b1, ADD, 1'b0);
      clk_edge();
      chk("resume phase", 32'(phase), 32'd3);
      for (int n = 0; n < 2; n++) begin apply(1'b1, ADD, 1'b0); clk_edge(); end
      chk("at phase 5", 32'(phase), 32'd5);
      async_reset("mid-instr");
`ifdef CTRL_INSTR_COUNT_EN
      chk("abandoned not counted", 32'(instr_count), 32'd0);
`endif

      // HLT: run=0 blocks the halt, run=1 latches it, then frozen at phase 4.
      for (int n = 0; n < 4; n++) begin apply(1'b1, ADD, 1'b0); clk_edge(); end
      apply(1'b0, HLT, 1'b0);
      chk("hlt decode halt", 32'(halt), 32'd1);
      chk("hlt decode inc_pc", 32'(inc_pc), 32'd1);
      clk_edge();
      apply(1'b0, ADD, 1'b0);
      chk("run0 no halt", 32'(halt), 32'd0);
      chk("run0 phase", 32'(phase), 32'd4);
      apply(1'b1, HLT, 1'b0);
      clk_edge();
      apply(1'b1, ADD, 1'b0);
      chk("halted flag", 32'(halt), 32'd1);
      chk("halted inc_pc", 32'(inc_pc), 32'd0);
      for (int n = 0; n < 20; n++) begin
         apply(1'($urandom_range(0, 1)), opcode_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         chk($sformatf("halted%0d phase", n), 32'(phase), 32'd4);
         chk_model($sformatf("halted%0d", n));
         clk_edge();
      end
      async_reset("halted");

      // Randomized run against the reference model with occasional async resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            async_reset($sformatf("rnd%0d", n));
         end else begin
            apply(1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 9) == 0) ? HLT : opcode_t'($urandom_range(1, 7)),
                  1'($urandom_range(0, 1)));
            chk_model($sformatf("rnd%0d", n));
            clk_edge();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/phase_controller.md
PHASE_CONTROLLER -- requirements
Module: phase_controller

Interface
- REQ-001: Parameter COUNT_W, default 16, is the width of the retired-instruction counter (used only when CTRL_INSTR_COUNT_EN is defined).
- REQ-002: Port clk, input, 1 bit: single clock; all state changes on its rising edge.
- REQ-003: Port rst, input, 1 bit: asynchronous, active-high reset.
- REQ-004: Port run, input, 1 bit: phase advance enable; when low, the phase holds.
- REQ-005: Port opcode, input, opcode_t from package opcodes: the current instruction opcode (HLT, SKZ, ADD, AND, XOR, LDA, STO, JMP).
- REQ-006: Port zero, input, 1 bit: accumulator-is-zero flag from the ALU.
- REQ-007: Ports sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac and wr are each an output of 1 bit. Meanings: address mux select (1 selects PC), memory read, load IR, increment PC, halted, load PC, data bus drive, load accumulator, memory write.
- REQ-008: Port phase, output, 3 bits: current phase number.
- REQ-009: Port instr_count, output, COUNT_W bits: count of retired instructions; the port is present only with CTRL_INSTR_COUNT_EN.

Function
- REQ-010: Phase counter sequence: 0 INST_ADDR, 1 INST_FETCH, 2 INST_LOAD, 3 IDLE, 4 OP_ADDR, 5 OP_FETCH, 6 ALU_OP, 7 STORE, then wrap 7->0.
- REQ-011: The phase advances by one per rising clk edge only when run=1 and the block is not halted; otherwise it holds.
- REQ-012: Define ALUOP = opcode in {ADD, AND, XOR, LDA}.
- REQ-013: All control outputs are combinational decodes of phase, opcode and zero; there is no added latency.
- REQ-014: sel=1 in phases 0-3, and 0 otherwise.
- REQ-015: rd=1 in phases 1-3, rd=ALUOP in phases 5-7, and 0 otherwise.
- REQ-016: ld_ir=1 in phases 2-3 only.
- REQ-017: inc_pc=1 in phase 4, inc_pc=(opcode==SKZ && zero) in phase 6, and 0 otherwise.
- REQ-018: ld_pc=(opcode==JMP) in phases 6-7, and 0 otherwise.
- REQ-019: data_e=(opcode==STO) in phases 6-7, and 0 otherwise.
- REQ-020: ld_ac=ALUOP in phase 7 only.
- REQ-021: wr=(opcode==STO) in phase 7 only.
- REQ-022: A rising edge in phase 4 with opcode==HLT sets the registered halted flag. The phase then freezes at 4.
- REQ-023: halt = halted flag, OR (phase==4 && opcode==HLT), so halt is asserted in the same cycle the HLT is decoded.
- REQ-024: While halted, inc_pc, ld_pc, rd, ld_ir, ld_ac, wr and data_e are forced to 0, regardless of opcode.
- REQ-025: Only reset clears halted; run has no effect on the halted state.
- REQ-026: run=0 coincident with HLT in phase 4 does not set halted. The HLT takes effect on the first edge where run=1.
- REQ-027: Outputs are X-free for any opcode value, including opcode changing mid-instruction; the decode uses the opcode present in each cycle.

Reset
- REQ-028: rst=1 asynchronously forces phase=0, halted=0 and instr_count=0, independent of clk.
- REQ-029: During reset, outputs reflect phase 0: sel=1 and all other control outputs 0.
- REQ-030: Reset asserted mid-instruction abandons that instruction; it is not counted.
- REQ-031: After rst deasserts, the first advance occurs on the first rising clk edge with run=1.

Configuration
- REQ-032: Macro CTRL_INSTR_COUNT_EN defined: instr_count increments by 1 on every edge that moves phase 7->0, and wraps from all-ones to 0.
- REQ-033: CTRL_INSTR_COUNT_EN undefined: the counter logic and the instr_count port are absent, and all other behaviour is identical.

Verification
- REQ-034: Reset, then run=1 with opcode=ADD and zero=0 for 8 clocks -> phase steps 0..7 back to 0. rd=1 in phases 1-3 and 5-7; ld_ac=1 only in phase 7; instr_count=1.
- REQ-035: opcode=SKZ, zero=1 -> inc_pc=1 in phase 4 and phase 6. With zero=0 -> inc_pc=1 in phase 4 only.
- REQ-036: opcode=STO -> data_e=1 in phases 6-7, wr=1 in phase 7 only, rd=0 in phases 5-7. opcode=JMP -> ld_pc=1 in phases 6-7.
- REQ-037: opcode=HLT at phase 4 -> halt=1 immediately; phase stays 4 for 20 clocks; inc_pc=0 after the edge. Assert rst -> phase=0 and halt=0 asynchronously.
- REQ-038: run=0 for 5 clocks at phase 2 -> phase and outputs hold; advance resumes when run=1. Asserting rst at phase 5 -> phase=0 without a clock edge, and instr_count is unchanged.
- REQ-039: With CTRL_INSTR_COUNT_EN and COUNT_W=4, run 16 instructions -> instr_count wraps 15->0.
